// File: rtl/dispense_sequencer.sv
// Dispense motor sequencer: arm, run until drop/timeout, settle gap, report done/fault.
// Latency: req to motor on is 2 cycles; drop_sns to decision is 2 sync cycles + 1; outputs registered.
// No backpressure: req is taken only in IDLE and never queued. Optional macro: DISPENSE_RETRY_EN.
module dispense_sequencer #(
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 200,
  parameter int GAP_CYCLES = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req,
  input  logic [1:0] i_prod,
  input  logic       i_drop_sns,
  input  logic       i_abort,
  input  logic       i_clr,
  output logic       o_motor_en,
  output logic [1:0] o_motor_sel,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_fault,
  output logic [1:0] o_lcd_msg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] L_TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] L_GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t           r_state;
  state_t           w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [1:0]       r_prod_q;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_motor_en;
  logic             r_busy;
  logic             r_done;
  logic             r_fault;
  logic [1:0]       r_lcd_msg;
  logic [1:0]       w_lcd_nxt;
`ifdef DISPENSE_RETRY_EN
  // r_retry: first RUN window already timed out; r_rearm: current GAP leads back to ARM
  logic             r_retry;
  logic             r_rearm;
  logic             w_retry_nxt;
  logic             w_rearm_nxt;
`endif

  // Two-flop synchronizer for the asynchronous drop sensor
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_drop_sns;
      r_sync2 <= r_sync1;
    end
  end

  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  // Next-state, counter and retry bookkeeping; abort overrides the active states
  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
`ifdef DISPENSE_RETRY_EN
    w_retry_nxt = r_retry;
    w_rearm_nxt = r_rearm;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_req) w_nxt = S_ARM;
      end
      S_ARM: begin
        w_cnt_nxt = '0;
        w_nxt     = S_RUN;
      end
      S_RUN: begin
        w_cnt_nxt = w_cnt_inc;
        if (r_sync2) begin
          // drop beats a simultaneous timeout
          w_nxt     = S_GAP;
          w_cnt_nxt = '0;
`ifdef DISPENSE_RETRY_EN
          w_rearm_nxt = 1'b0;
`endif
        end else if (r_cnt == L_TO_LAST) begin
`ifdef DISPENSE_RETRY_EN
          if (!r_retry) begin
            w_nxt       = S_GAP;
            w_cnt_nxt   = '0;
            w_retry_nxt = 1'b1;
            w_rearm_nxt = 1'b1;
          end else begin
            w_nxt = S_FAULT;
          end
`else
          w_nxt = S_FAULT;
`endif
        end
      end
      S_GAP: begin
        if (r_cnt == L_GAP_LAST) begin
          w_cnt_nxt = '0;
`ifdef DISPENSE_RETRY_EN
          w_nxt = r_rearm ? S_ARM : S_DONE;
`else
          w_nxt = S_DONE;
`endif
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_DONE: begin
        w_nxt = S_IDLE;
      end
      S_FAULT: begin
        if (i_clr) w_nxt = S_IDLE;
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
    if (i_abort && (r_state == S_ARM || r_state == S_RUN || r_state == S_GAP)) begin
      w_nxt = S_IDLE;
    end
    if (w_nxt == S_IDLE) begin
      w_cnt_nxt = '0;
`ifdef DISPENSE_RETRY_EN
      w_retry_nxt = 1'b0;
      w_rearm_nxt = 1'b0;
`endif
    end
  end

  // LCD code for the state being entered
  always_comb begin
    w_lcd_nxt = 2'b00;
    case (w_nxt)
      S_ARM, S_RUN, S_GAP: w_lcd_nxt = 2'b01;
      S_DONE:              w_lcd_nxt = 2'b10;
      S_FAULT:             w_lcd_nxt = 2'b11;
      default:             w_lcd_nxt = 2'b00;
    endcase
  end

  // State register with Moore outputs registered from the state being entered
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_prod_q   <= 2'b00;
      r_motor_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
      r_lcd_msg  <= 2'b00;
`ifdef DISPENSE_RETRY_EN
      r_retry    <= 1'b0;
      r_rearm    <= 1'b0;
`endif
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt_nxt;
      if (r_state == S_IDLE && i_req) r_prod_q <= i_prod;
      r_motor_en <= (w_nxt == S_RUN);
      r_busy     <= (w_nxt != S_IDLE);
      r_done     <= (w_nxt == S_DONE);
      r_fault    <= (w_nxt == S_FAULT);
      r_lcd_msg  <= w_lcd_nxt;
`ifdef DISPENSE_RETRY_EN
      r_retry    <= w_retry_nxt;
      r_rearm    <= w_rearm_nxt;
`endif
    end
  end

  assign o_motor_en  = r_motor_en;
  assign o_motor_sel = r_prod_q;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_fault     = r_fault;
  assign o_lcd_msg   = r_lcd_msg;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer with an outcome scoreboard.
// Each request pushes its expected product and ending (done, fault or abort).
// The observer pops an entry whenever the DUT ends a transaction.
module tb_dispense_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic [1:0] prod = 2'b00;
  logic       drop_sns = 1'b0;
  logic       abort = 1'b0;
  logic       clr = 1'b0;
  logic       motor_en;
  logic [1:0] motor_sel;
  logic       busy;
  logic       done;
  logic       fault;
  logic [1:0] lcd_msg;

  typedef enum int {EV_DONE = 0, EV_FAULT = 1, EV_ABORT = 2} ev_t;
  typedef struct {
    logic [1:0] prod;
    ev_t        ev;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   run_len, off_len, done_cnt;

  dispense_sequencer dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req       (req),
    .i_prod      (prod),
    .i_drop_sns  (drop_sns),
    .i_abort     (abort),
    .i_clr       (clr),
    .o_motor_en  (motor_en),
    .o_motor_sel (motor_sel),
    .o_busy      (busy),
    .o_done      (done),
    .o_fault     (fault),
    .o_lcd_msg   (lcd_msg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input ev_t ev);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_unexpected_event", 32'(ev), 32'hFFFF);
    end else begin
      e = sb_q.pop_front();
      chk("sb_event", 32'(ev), 32'(e.ev));
      chk("sb_motor_sel", 32'(motor_sel), 32'(e.prod));
    end
  endtask

  // Request a dispense and check the one-cycle ARM state that follows
  task automatic issue(input logic [1:0] p, input ev_t ev);
    exp_t e;
    e.prod = p;
    e.ev   = ev;
    sb_q.push_back(e);
    req  = 1'b1;
    prod = p;
    tick();
    req  = 1'b0;
    prod = ~p;
    chk("arm_busy", 32'(busy), 1);
    chk("arm_motor_en", 32'(motor_en), 0);
    chk("arm_lcd", 32'(lcd_msg), 1);
    chk("arm_motor_sel", 32'(motor_sel), 32'(p));
  endtask

  // Follow one transaction: inject drop/abort at a given RUN cycle index, count phases
  task automatic observe(input int drop_at, input int abort_at, input int budget,
                         output int r_len, output int o_len, output int d_cnt);
    bit ended;
    r_len = 0;
    o_len = 0;
    d_cnt = 0;
    ended = 1'b0;
    for (int c = 0; c < budget && !ended; c++) begin
      if (done) begin
        d_cnt++;
        chk("done_lcd", 32'(lcd_msg), 2);
        pop_chk(EV_DONE);
      end
      if (fault) begin
        chk("fault_lcd", 32'(lcd_msg), 3);
        chk("fault_motor_off", 32'(motor_en), 0);
        pop_chk(EV_FAULT);
        ended = 1'b1;
      end else if (!busy) begin
        if (d_cnt == 0) pop_chk(EV_ABORT);
        ended = 1'b1;
      end else if (motor_en) begin
        if (r_len == 0) chk("run_lcd", 32'(lcd_msg), 1);
        if (r_len == drop_at) drop_sns = 1'b1;
        if (r_len == abort_at) abort = 1'b1;
        r_len++;
      end else if (!done) begin
        o_len++;
      end
      if (!ended) begin
        tick();
        abort = 1'b0;
      end
    end
    chk("txn_ended_in_budget", 32'(ended), 1);
    drop_sns = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    // Reset state: outputs low with reset asserted
    #1;
    chk("rst_motor_en", 32'(motor_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_lcd", 32'(lcd_msg), 0);
    chk("rst_motor_sel", 32'(motor_sel), 0);
    #11;
    reset = 1'b1;
    repeat (2) tick();

    // Normal delivery: drop at RUN cycle 20 -> 23 motor cycles, ARM + 8 GAP, one done
    issue(2'b10, EV_DONE);
    observe(20, -1, 400, run_len, off_len, done_cnt);
    chk("t1_run_len", 32'(run_len), 23);
    chk("t1_off_len", 32'(off_len), 9);
    chk("t1_done_cnt", 32'(done_cnt), 1);

    // No drop: timeout
    issue(2'b01, EV_FAULT);
    observe(-1, -1, 900, run_len, off_len, done_cnt);
`ifdef DISPENSE_RETRY_EN
    chk("t2_run_len", 32'(run_len), 400);
    chk("t2_off_len", 32'(off_len), 10);
`else
    chk("t2_run_len", 32'(run_len), 200);
    chk("t2_off_len", 32'(off_len), 1);
`endif
    chk("t2_done_cnt", 32'(done_cnt), 0);
    // req while faulted is ignored
    req  = 1'b1;
    prod = 2'b11;
    tick();
    req  = 1'b0;
    tick();
    chk("t2_fault_holds", 32'(fault), 1);
    chk("t2_fault_lcd", 32'(lcd_msg), 3);
    chk("t2_sel_unchanged", 32'(motor_sel), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t2_clr_fault", 32'(fault), 0);
    chk("t2_clr_busy", 32'(busy), 0);
    chk("t2_clr_lcd", 32'(lcd_msg), 0);
    repeat (2) tick();

    // drop_s high on RUN counter 199: drop beats timeout
    issue(2'b11, EV_DONE);
    observe(197, -1, 400, run_len, off_len, done_cnt);
    chk("t3_run_len", 32'(run_len), 200);
    chk("t3_off_len", 32'(off_len), 9);
    chk("t3_done_cnt", 32'(done_cnt), 1);
    chk("t3_no_fault", 32'(fault), 0);

    // Abort at RUN cycle 50
    issue(2'b00, EV_ABORT);
    observe(-1, 50, 400, run_len, off_len, done_cnt);
    chk("t4_run_len", 32'(run_len), 51);
    chk("t4_done_cnt", 32'(done_cnt), 0);
    chk("t4_motor_off", 32'(motor_en), 0);
    chk("t4_busy", 32'(busy), 0);

    // Reset mid-RUN clears outputs without a clock edge
    req  = 1'b1;
    prod = 2'b10;
    tick();
    req  = 1'b0;
    repeat (11) tick();
    chk("t5_running", 32'(motor_en), 1);
    reset = 1'b0;
    #1;
    chk("t5_rst_motor_en", 32'(motor_en), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_lcd", 32'(lcd_msg), 0);
    chk("t5_rst_sel", 32'(motor_sel), 0);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    issue(2'b01, EV_DONE);
    observe(5, -1, 400, run_len, off_len, done_cnt);
    chk("t5_run_len", 32'(run_len), 8);
    chk("t5_off_len", 32'(off_len), 9);
    chk("t5_done_cnt", 32'(done_cnt), 1);

`ifdef DISPENSE_RETRY_EN
    // Retry: drop in the second RUN window at its cycle 30
    issue(2'b10, EV_DONE);
    observe(230, -1, 900, run_len, off_len, done_cnt);
    chk("t6_run_len", 32'(run_len), 233);
    chk("t6_off_len", 32'(off_len), 18);
    chk("t6_done_cnt", 32'(done_cnt), 1);
`endif

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
